// File: rtl/ascon_io_pkg.sv
// ascon_io_pkg
// Shared definitions for the Ascon wrapper output-port consumer:
//   state_t    - controller / serializer state encoding
//   UART_IDLE  - idle (mark) level of the UART line
//   num_bytes  - ciphertext + tag length in bytes
package ascon_io_pkg;

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        WAIT,
        CAPTURE,
        START,
        DATA,
        PARITY,
        STOP,
        WRAP,
        DONE,
        REARM
    } state_t;

    localparam logic UART_IDLE = 1'b1;

    function automatic int num_bytes(input int y, input int tag_bits);
        return (y + tag_bits) / 8;
    endfunction

endpackage

// File: rtl/uart_tx_bit.sv
// uart_tx_bit
// Byte serializer for a UART line: start bit, 8 data bits LSB first,
// optional even-parity bit, stop bit. Every bit lasts CLKS_PER_BIT cycles.
// Build option: ASCON_TX_PARITY_EN adds the parity bit (11-bit frame).
// Ports:
//   clk, rst  - clock, synchronous active-low reset
//   load      - start a frame with data (ignored while busy)
//   data      - byte to send
//   busy      - high while a frame is on the line
//   tx        - UART line, idle high
module uart_tx_bit
    import ascon_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    state_t           phase_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;
`ifdef ASCON_TX_PARITY_EN
    logic             par_q;
`endif

    // tx is registered so each bit starts exactly on a divider boundary
    // and a reset forces the line idle on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= UART_IDLE;
`ifdef ASCON_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (phase_q == IDLE) begin
            if (load) begin
                phase_q <= START;
                div_q   <= '0;
                idx_q   <= '0;
                shift_q <= data;
                tx_q    <= 1'b0;
`ifdef ASCON_TX_PARITY_EN
                par_q   <= ^data;
`endif
            end
        end else if (div_q != DIV_LAST) begin
            div_q <= div_q + 1'b1;
        end else begin
            div_q <= '0;
            case (phase_q)
                START: begin
                    phase_q <= DATA;
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    idx_q   <= '0;
                end
                DATA: begin
                    if (idx_q == 3'd7) begin
`ifdef ASCON_TX_PARITY_EN
                        phase_q <= PARITY;
                        tx_q    <= par_q;
`else
                        phase_q <= STOP;
                        tx_q    <= UART_IDLE;
`endif
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
`ifdef ASCON_TX_PARITY_EN
                PARITY: begin
                    phase_q <= STOP;
                    tx_q    <= UART_IDLE;
                end
`endif
                default: begin
                    // end of stop bit (or an unreachable phase): back to idle
                    phase_q <= IDLE;
                    tx_q    <= UART_IDLE;
                end
            endcase
        end
    end

    assign busy = (phase_q != IDLE);
    assign tx   = tx_q;

endmodule

// File: rtl/ascon_out_uart_tx.sv
// ascon_out_uart_tx
// Reads the Ascon wrapper's ciphertext+tag one byte per output strobe and
// sends each byte as a UART frame, then strobes once more so the wrapper's
// output index wraps to 0. After a message it waits for ready to drop
// before accepting another, so a held ready is not retransmitted.
// Build option: ASCON_TX_PARITY_EN (even parity bit, see uart_tx_bit).
// Ports:
//   clk, rst     - clock, synchronous active-low reset
//   ready_i      - wrapper encryption ready
//   byte_i       - wrapper output byte, valid the cycle after a strobe
//   out_strobe_o - one-cycle output-select pulse to the wrapper
//   tx_o         - UART line, idle high
//   busy_o       - message in progress
//   done_o       - one-cycle pulse when a message has completed
//   err_o        - sticky: ready was low when the next byte was due
module ascon_out_uart_tx
    import ascon_io_pkg::*;
#(
    parameter int Y            = 16,
    parameter int TAG_BITS     = 128,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready_i,
    input  logic [7:0] byte_i,
    output logic       out_strobe_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int NUM_BYTES = num_bytes(Y, TAG_BITS);
    localparam int CNT_W     = $clog2(NUM_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             strobe;
    logic             load;
    logic             ser_busy;

    uart_tx_bit #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .data (byte_i),
        .busy (ser_busy),
        .tx   (tx_o)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // START stands for the whole frame: the serializer sequences
    // start/data/parity/stop itself and the controller waits for it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        strobe  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ready_i) begin
                    err_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ready_i) begin
                    strobe  = 1'b1;
                    state_d = WAIT;
                end else begin
                    // abandon the message; restart byte numbering so a
                    // later message is not sent short
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            WAIT:    state_d = CAPTURE;   // wrapper output register latency
            CAPTURE: begin
                load    = 1'b1;
                state_d = START;
            end
            START: begin
                if (!ser_busy) begin
                    if (cnt_q < CNT_LAST) begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = REQ;
                    end else begin
                        state_d = WRAP;
                    end
                end
            end
            WRAP: begin
                strobe  = 1'b1;           // returned byte is not used
                state_d = DONE;
            end
            DONE: begin
                cnt_d   = '0;
                state_d = REARM;
            end
            REARM: begin
                if (!ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_strobe_o = strobe;
    assign busy_o       = state_q inside {REQ, WAIT, CAPTURE, START, WRAP};
    assign done_o       = (state_q == DONE);
    assign err_o        = err_q;

endmodule
